serial_add_sub: RTL and testbench
=================================

// Module: serial_add_sub
// PURPOSE
//  Bit-serial adder-subtractor: computes A+B or A-B (two's complement) one bit per
//  clock, LSB first, through a single full-adder cell and a carry/borrow flip-flop.
//  Area-lean sequential alternative to the ripple four-bit adder-subtractor.
//  Operands enter on a start/busy handshake; the result is held until acknowledged.
// PARAMETERS
//  WIDTH  4  operand/result width in bits, >=2
// PORTS
//  clk      in   1      rising-edge clock, sole clock
//  rst_n    in   1      asynchronous, active-low reset
//  start    in   1      request; accepted only when busy=0 and valid=0
//  mode     in   1      0=add, 1=subtract; sampled with start
//  a        in   WIDTH  operand A; sampled with start
//  b        in   WIDTH  operand B; sampled with start
//  busy     out  1      high while SHIFT state active
//  valid    out  1      result/cout stable and valid; high in DONE
//  ack      in   1      consumer acknowledge; meaningful only while valid=1
//  result   out  WIDTH  sum or difference, modulo 2^WIDTH
//  cout     out  1      final carry; in subtract mode 1 = no borrow (A>=B unsigned)
//  ovf      out  1      signed overflow; present only with ADDSUB_OVF_EN
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; busy=0, valid=0, result=0, cout=0, ovf=0,
//   internal shift regs, bit counter and carry FF cleared. Reset mid-operation
//   abandons the operation; no partial result is ever flagged valid.
//  FSM: IDLE -> SHIFT on start (in IDLE); SHIFT -> DONE after WIDTH bit-cycles;
//   DONE -> IDLE on ack. Only these transitions exist.
//  IDLE accept edge: a_sh<=a, b_sh<=b^{WIDTH{mode}}, carry<=mode, cnt<=0, busy<=1.
//  SHIFT, each edge: s=a_sh[0]^b_sh[0]^carry; carry<=majority(a_sh[0],b_sh[0],carry);
//   a_sh,b_sh shift right by 1; s shifted into result from MSB side; cnt<=cnt+1.
//   Edge with cnt==WIDTH-1 processes the MSB, then state<=DONE, busy<=0, valid<=1,
//   cout<=carry out of the MSB cell.
//  Latency: valid rises exactly WIDTH clock edges after the accepting edge.
//  DONE: result/cout/ovf held constant while valid=1, regardless of start/a/b/mode.
//   ack=1 in DONE: valid<=0 next edge, state IDLE; outputs keep last value.
//   A new start is not accepted on the same edge as ack (earliest: next cycle).
//  start while busy=1 or valid=1: ignored, no queueing. ack outside DONE: ignored.
//  result visible on port during SHIFT is partial and undefined to consumers.
//  Arithmetic is modulo 2^WIDTH; A-B = A + ~B + 1. Counter width $clog2(WIDTH)+1.
// CONFIGURATION
//  ADDSUB_OVF_EN defined: port ovf exists; on entry to DONE
//   ovf<=carry_into_MSB ^ carry_out_of_MSB; reset 0; held like result.
//  ADDSUB_OVF_EN undefined: no ovf port, no overflow logic; all else identical.
// TESTING (WIDTH=4)
//  add 7+9 -> valid after 4 edges, result=0000, cout=1 (ovf=0)
//  sub 5-3 -> result=0010, cout=1; sub 3-5 -> result=1110, cout=0
//  OVF_EN: add 7+1 -> result=1000, ovf=1; sub 8-1 (-8-1) -> result=0111, ovf=1
//  start pulse with new operands during SHIFT and during DONE -> ignored; result
//   stays from first op; valid held 10 cycles until ack, then drops next edge
//  rst_n low on 2nd SHIFT cycle -> all outputs 0 immediately; after release, new
//   add 1+1 -> result=0010, cout=0, exact 4-edge latency
//  exhaustive: all 256 a,b pairs x both modes back-to-back vs. reference model

Source files
------------

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor.
//   Computes A+B or A-B (two's complement) one bit per clock, LSB first,
//   through a single full-adder cell and a carry/borrow flip-flop.
//   Operands are taken on a start/busy handshake.  The result is held with
//   valid=1 until it is acknowledged.
// Optional feature: define ADDSUB_OVF_EN to add the signed-overflow output ovf.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request; accepted only in IDLE (busy=0, valid=0)
//   mode    0=add, 1=subtract; sampled with start
//   a, b    operands; sampled with start
//   busy    high while bits are being shifted
//   valid   result/cout (and ovf) valid and held
//   ack     consumer acknowledge; used only while valid=1
//   result  sum/difference modulo 2^WIDTH
//   ovf     signed overflow (ADDSUB_OVF_EN only)
//   cout    final carry; in subtract mode 1 means no borrow (A>=B unsigned)
module serial_add_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             valid,
    input  logic             ack,
    output logic [WIDTH-1:0] result,
`ifdef ADDSUB_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept, last;
    logic             s, c_nxt;

    // The full-adder cell is shared by every bit position.
    assign s      = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_nxt  = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign accept = (state == IDLE) && start;
    assign last   = (cnt == CW'(WIDTH - 1));

    assign busy  = (state == SHIFT);
    assign valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Start is ignored outside IDLE.  An ack in DONE returns to IDLE only, so
    // a start on the same edge as ack is not taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last)  state_nxt = DONE;
            DONE:    if (ack)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
`ifdef ADDSUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else if (accept) begin
            // Subtraction is A + ~B + 1: invert B and preload carry with 1.
            a_sh  <= a;
            b_sh  <= b ^ {WIDTH{mode}};
            carry <= mode;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            carry  <= c_nxt;
            result <= {s, result[WIDTH-1:1]};
            cnt    <= cnt + CW'(1);
            if (last) begin
                cout <= c_nxt;
`ifdef ADDSUB_OVF_EN
                // On the MSB cycle, carry holds the carry into the MSB.
                ovf  <= carry ^ c_nxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed self-checking bench for serial_add_sub (WIDTH=4).
// Every task starts and ends just after a falling clock edge. Inputs are
// driven there, and outputs are sampled there.
module tb_serial_add_sub;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ack = 1'b0;
    logic         busy, valid, cout;
    logic [W-1:0] result;
`ifdef ADDSUB_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
        .busy(busy), .valid(valid), .ack(ack), .result(result),
`ifdef ADDSUB_OVF_EN
        .ovf(ovf),
`endif
        .cout(cout)
    );

    // Issue one request from IDLE.  Return the number of rising edges from
    // the accepting edge to valid, capped at 20.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic im, output int lat);
        a = ia; b = ib; mode = im; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({busy, valid, result, cout} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b valid=%b result=%b cout=%b, required all 0",
                     busy, valid, result, cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        int lat;
        run_op(4'd7, 4'd9, 1'b0, lat);
        n_checks++;
        if (lat !== 4 || result !== 4'b0000 || cout !== 1'b1) begin
            n_fail++;
            $display("FAIL add_7_9: lat=%0d result=%b cout=%b, required lat=4 result=0000 cout=1",
                     lat, result, cout);
        end
`ifdef ADDSUB_OVF_EN
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL add_7_9_ovf: ovf=%b, required 0", ovf);
        end
`endif
        do_ack();
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_drop: valid=%b busy=%b, required 0 0", valid, busy);
        end
    endtask

    task automatic test_sub();
        int lat;
        run_op(4'd5, 4'd3, 1'b1, lat);
        n_checks++;
        if (lat !== 4 || result !== 4'b0010 || cout !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_5_3: lat=%0d result=%b cout=%b, required lat=4 result=0010 cout=1",
                     lat, result, cout);
        end
        do_ack();
        run_op(4'd3, 4'd5, 1'b1, lat);
        n_checks++;
        if (lat !== 4 || result !== 4'b1110 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_3_5: lat=%0d result=%b cout=%b, required lat=4 result=1110 cout=0",
                     lat, result, cout);
        end
        do_ack();
    endtask

`ifdef ADDSUB_OVF_EN
    task automatic test_ovf();
        int lat;
        run_op(4'd7, 4'd1, 1'b0, lat);
        n_checks++;
        if (result !== 4'b1000 || ovf !== 1'b1 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_add_7_1: result=%b ovf=%b cout=%b, required 1000 1 0",
                     result, ovf, cout);
        end
        do_ack();
        run_op(4'd8, 4'd1, 1'b1, lat);
        n_checks++;
        if (result !== 4'b0111 || ovf !== 1'b1 || cout !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sub_8_1: result=%b ovf=%b cout=%b, required 0111 1 1",
                     result, ovf, cout);
        end
        do_ack();
    endtask
`endif

    // A start pulse during SHIFT and another during DONE must both be ignored.
    // A start asserted with ack must not be accepted on that edge.
    task automatic test_ignore_start();
        int lat;
        int bad;
        a = 4'd5; b = 4'd6; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        @(negedge clk); lat++;
        a = 4'd15; b = 4'd15; mode = 1'b1; start = 1'b1;
        @(negedge clk); lat++;
        start = 1'b0;
        while (!valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat !== 4 || result !== 4'b1011 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_shift: lat=%0d result=%b cout=%b, required lat=4 result=1011 cout=0",
                     lat, result, cout);
        end
        a = 4'd1; b = 4'd2; mode = 1'b0; start = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (valid !== 1'b1 || busy !== 1'b0 || result !== 4'b1011 || cout !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_in_done: %0d bad cycles, last valid=%b result=%b, required valid=1 result=1011",
                     bad, valid, result);
        end
        ack = 1'b1; start = 1'b1; a = 4'd2; b = 4'd2;
        @(negedge clk);
        ack = 1'b0; start = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || result !== 4'b1011) begin
            n_fail++;
            $display("FAIL ack_with_start: valid=%b busy=%b result=%b, required 0 0 1011",
                     valid, busy, result);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL no_late_accept: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        a = 4'd9; b = 4'd4; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, valid, result, cout} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b valid=%b result=%b cout=%b, required all 0",
                     busy, valid, result, cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: valid=%b busy=%b, required 0 0", valid, busy);
        end
        run_op(4'd1, 4'd1, 1'b0, lat);
        n_checks++;
        if (lat !== 4 || result !== 4'b0010 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_1_1: lat=%0d result=%b cout=%b, required lat=4 result=0010 cout=0",
                     lat, result, cout);
        end
        do_ack();
    endtask

    // Run all operand pairs in both modes, back to back, against a
    // whole-word arithmetic reference.
    task automatic test_back_to_back();
        int lat;
        int bad;
        logic [W:0]   ref_sum;
        logic [W-1:0] ra, rb;
`ifdef ADDSUB_OVF_EN
        logic         ref_ovf;
`endif
        bad = 0;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    ra = W'(i); rb = W'(j);
                    if (m == 0) ref_sum = {1'b0, ra} + {1'b0, rb};
                    else        ref_sum = {1'b0, ra} + {1'b0, ~rb} + 5'd1;
`ifdef ADDSUB_OVF_EN
                    if (m == 0) ref_ovf = (ra[W-1] == rb[W-1]) && (ref_sum[W-1] != ra[W-1]);
                    else        ref_ovf = (ra[W-1] != rb[W-1]) && (ref_sum[W-1] != ra[W-1]);
`endif
                    run_op(ra, rb, m[0], lat);
                    n_checks++;
                    if (lat !== 4 || result !== ref_sum[W-1:0] || cout !== ref_sum[W]
`ifdef ADDSUB_OVF_EN
                        || ovf !== ref_ovf
`endif
                    ) begin
                        n_fail++;
                        bad++;
                        if (bad <= 8)
                            $display("FAIL exhaustive m=%0d a=%0d b=%0d: lat=%0d result=%b cout=%b, required lat=4 result=%b cout=%b",
                                     m, i, j, lat, result, cout, ref_sum[W-1:0], ref_sum[W]);
                    end
                    do_ack();
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
`ifdef ADDSUB_OVF_EN
        test_ovf();
`endif
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
